// File: rtl/pr_request_queue_if.sv
// pr_request_queue_if: bundles the core request/completion handshake and the
// 4-register AXI-lite port of the PR request queue.
// slave  = the queue controller.
// master = the core plus the host that drive it.
interface pr_request_queue_if #(
    parameter int REQ_W = 16
);
    logic             req_valid;
    logic [REQ_W-1:0] req_data;
    logic             req_ready;
    logic             done_valid;
    logic [REQ_W-1:0] done_id;
    logic             pr_request_pending;
    logic [1:0]       s_axi_awaddr;
    logic             s_axi_awvalid;
    logic             s_axi_awready;
    logic [31:0]      s_axi_wdata;
    logic             s_axi_wvalid;
    logic             s_axi_wready;
    logic             s_axi_bvalid;
    logic             s_axi_bready;
    logic [1:0]       s_axi_araddr;
    logic             s_axi_arvalid;
    logic             s_axi_arready;
    logic [31:0]      s_axi_rdata;
    logic             s_axi_rvalid;
    logic             s_axi_rready;

    modport slave (
        input  req_valid, req_data,
        output req_ready, done_valid, done_id, pr_request_pending,
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
        output s_axi_awready, s_axi_wready, s_axi_bvalid,
        input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_arready, s_axi_rdata, s_axi_rvalid
    );

    modport master (
        output req_valid, req_data,
        input  req_ready, done_valid, done_id, pr_request_pending,
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
        input  s_axi_awready, s_axi_wready, s_axi_bvalid,
        output s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_arready, s_axi_rdata, s_axi_rvalid
    );
endinterface

// File: rtl/pr_request_queue_ctrl.sv
// pr_request_queue_ctrl: FIFO of partial-reconfiguration requests pushed by the
// core and serviced by host software over a 4-register AXI-lite port
// (0 HEAD, 1 STATUS, 2 DONE, 3 CTRL).
// Optional macro PR_QUEUE_STATS_EN adds a saturating 16-bit accepted-push
// counter visible in STATUS[31:16]; without it those bits read 0.
module pr_request_queue_ctrl #(
    parameter int DEPTH = 4,
    parameter int REQ_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    pr_request_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0] ZERO_PTR = PTR_W'(0);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    logic [REQ_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
    logic [CNT_W-1:0] count_r, count_next_s;
    logic             enable_r, enable_next_s;
    logic             req_ready_r, pending_r, done_valid_r;
    logic [REQ_W-1:0] done_id_r;
    w_state_t         w_state_r, w_state_next_s;
    r_state_t         r_state_r, r_state_next_s;
    logic             aw_latched_r, w_latched_r, awready_r, wready_r, bvalid_r;
    logic [1:0]       awaddr_r;
    logic [31:0]      wdata_r;
    logic             arready_r, rvalid_r;
    logic [31:0]      rdata_r, rd_mux_s;
    logic [15:0]      stats_s;
    logic             empty_s, full_s, push_s, pop_s, flush_s, done_wr_s, ctrl_wr_s;
    logic             aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    logic [1:0]       wr_addr_s;
    logic [31:0]      wr_data_s;
    logic             unused_s;

    assign empty_s = (count_r == ZERO_CNT);
    assign full_s  = (count_r == FULL_CNT);
    assign push_s  = bus.req_valid & req_ready_r;

    // AW and W are latched independently; the write commits once both are held.
    assign aw_hs_s   = bus.s_axi_awvalid & awready_r;
    assign w_hs_s    = bus.s_axi_wvalid & wready_r;
    assign ar_hs_s   = bus.s_axi_arvalid & arready_r;
    assign commit_s  = (w_state_r == W_IDLE) & (aw_latched_r | aw_hs_s) & (w_latched_r | w_hs_s);
    assign wr_addr_s = aw_latched_r ? awaddr_r : bus.s_axi_awaddr;
    assign wr_data_s = w_latched_r ? wdata_r : bus.s_axi_wdata;
    assign pop_s     = commit_s & (wr_addr_s == 2'd0) & ~empty_s;
    assign done_wr_s = commit_s & (wr_addr_s == 2'd2);
    assign ctrl_wr_s = commit_s & (wr_addr_s == 2'd3);
    assign flush_s   = ctrl_wr_s & wr_data_s[1];
    assign unused_s  = ^wr_data_s;

`ifdef PR_QUEUE_STATS_EN
    logic [15:0] stat_cnt_r;

    // Saturating count of accepted pushes, cleared by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt_r <= 16'h0000;
        end else if (flush_s) begin
            stat_cnt_r <= 16'h0000;
        end else if (push_s && (stat_cnt_r != 16'hFFFF)) begin
            stat_cnt_r <= stat_cnt_r + 16'h0001;
        end
    end
    assign stats_s = stat_cnt_r;
`else
    assign stats_s = 16'h0000;
`endif

    // Next FIFO pointers/count and enable; flush beats any push or pop.
    always_comb begin
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        count_next_s  = count_r;
        enable_next_s = enable_r;
        if (ctrl_wr_s) begin
            enable_next_s = wr_data_s[0];
        end else begin
            enable_next_s = enable_r;
        end
        if (flush_s) begin
            wr_ptr_next_s = ZERO_PTR;
            rd_ptr_next_s = ZERO_PTR;
            count_next_s  = ZERO_CNT;
        end else begin
            if (push_s) begin
                wr_ptr_next_s = wr_ptr_r + ONE_PTR;
            end else begin
                wr_ptr_next_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_next_s = rd_ptr_r + ONE_PTR;
            end else begin
                rd_ptr_next_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + ONE_CNT;
                2'b01:   count_next_s = count_r - ONE_CNT;
                default: count_next_s = count_r;
            endcase
        end
    end

    // FIFO storage, pointers and core-facing status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {REQ_W{1'b0}};
            end
            wr_ptr_r     <= ZERO_PTR;
            rd_ptr_r     <= ZERO_PTR;
            count_r      <= ZERO_CNT;
            enable_r     <= 1'b1;
            req_ready_r  <= 1'b1;
            pending_r    <= 1'b0;
            done_valid_r <= 1'b0;
            done_id_r    <= {REQ_W{1'b0}};
        end else begin
            if (push_s && !flush_s) begin
                mem_r[wr_ptr_r] <= bus.req_data;
            end
            wr_ptr_r     <= wr_ptr_next_s;
            rd_ptr_r     <= rd_ptr_next_s;
            count_r      <= count_next_s;
            enable_r     <= enable_next_s;
            req_ready_r  <= enable_next_s & (count_next_s != FULL_CNT);
            pending_r    <= (count_next_s != ZERO_CNT);
            done_valid_r <= done_wr_s;
            if (done_wr_s) begin
                done_id_r <= wr_data_s[REQ_W-1:0];
            end
        end
    end

    // Write FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_r <= W_IDLE;
        end else begin
            w_state_r <= w_state_next_s;
        end
    end

    // Write FSM next state: idle until commit, then hold response until bready.
    always_comb begin
        w_state_next_s = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (commit_s) w_state_next_s = W_RESP;
                else          w_state_next_s = W_IDLE;
            end
            W_RESP: begin
                if (bus.s_axi_bready) w_state_next_s = W_IDLE;
                else                  w_state_next_s = W_RESP;
            end
            default: w_state_next_s = W_IDLE;
        endcase
    end

    // Write channel latches and registered AW/W ready and B valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_latched_r <= 1'b0;
            w_latched_r  <= 1'b0;
            awaddr_r     <= 2'd0;
            wdata_r      <= 32'h0000_0000;
            awready_r    <= 1'b0;
            wready_r     <= 1'b0;
            bvalid_r     <= 1'b0;
        end else if (commit_s) begin
            aw_latched_r <= 1'b0;
            w_latched_r  <= 1'b0;
            awready_r    <= 1'b0;
            wready_r     <= 1'b0;
            bvalid_r     <= 1'b1;
        end else if (w_state_r == W_RESP) begin
            if (bus.s_axi_bready) begin
                bvalid_r  <= 1'b0;
                awready_r <= 1'b1;
                wready_r  <= 1'b1;
            end
        end else begin
            if (aw_hs_s) begin
                aw_latched_r <= 1'b1;
                awaddr_r     <= bus.s_axi_awaddr;
                awready_r    <= 1'b0;
            end else begin
                awready_r <= ~aw_latched_r;
            end
            if (w_hs_s) begin
                w_latched_r <= 1'b1;
                wdata_r     <= bus.s_axi_wdata;
                wready_r    <= 1'b0;
            end else begin
                wready_r <= ~w_latched_r;
            end
        end
    end

    // Register read mux over the current (pre-update) state.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (bus.s_axi_araddr)
            2'd0: begin
                rd_mux_s[REQ_W-1:0] = mem_r[rd_ptr_r];
                rd_mux_s[31]        = ~empty_s;
            end
            2'd1: begin
                rd_mux_s[CNT_W-1:0] = count_r;
                rd_mux_s[8]         = full_s;
                rd_mux_s[9]         = empty_s;
                rd_mux_s[31:16]     = stats_s;
            end
            2'd2:    rd_mux_s[REQ_W-1:0] = done_id_r;
            2'd3:    rd_mux_s[0] = enable_r;
            default: rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_r <= R_IDLE;
        end else begin
            r_state_r <= r_state_next_s;
        end
    end

    // Read FSM next state: accept AR when idle, hold data until rready.
    always_comb begin
        r_state_next_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) r_state_next_s = R_DATA;
                else         r_state_next_s = R_IDLE;
            end
            R_DATA: begin
                if (bus.s_axi_rready) r_state_next_s = R_IDLE;
                else                  r_state_next_s = R_DATA;
            end
            default: r_state_next_s = R_IDLE;
        endcase
    end

    // Read channel: capture rdata on AR, hold it with rvalid until rready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'h0000_0000;
        end else if (ar_hs_s) begin
            rdata_r   <= rd_mux_s;
            rvalid_r  <= 1'b1;
            arready_r <= 1'b0;
        end else if (r_state_r == R_DATA) begin
            if (bus.s_axi_rready) begin
                rvalid_r  <= 1'b0;
                arready_r <= 1'b1;
            end
        end else begin
            arready_r <= 1'b1;
        end
    end

    assign bus.req_ready          = req_ready_r;
    assign bus.pr_request_pending = pending_r;
    assign bus.done_valid         = done_valid_r;
    assign bus.done_id            = done_id_r;
    assign bus.s_axi_awready      = awready_r;
    assign bus.s_axi_wready       = wready_r;
    assign bus.s_axi_bvalid       = bvalid_r;
    assign bus.s_axi_arready      = arready_r;
    assign bus.s_axi_rvalid       = rvalid_r;
    assign bus.s_axi_rdata        = rdata_r;
endmodule

// File: tb/tb_pr_request_queue_ctrl.sv
// tb_pr_request_queue_ctrl: directed plus randomized stimulus against a
// queue-level reference model; read data and completion IDs go through
// scoreboards checked by independent monitors.
module tb_pr_request_queue_ctrl;
    localparam int DEPTH = 4;
    localparam int REQ_W = 16;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    pr_request_queue_if #(.REQ_W(REQ_W)) bus ();

    pr_request_queue_ctrl #(.DEPTH(DEPTH), .REQ_W(REQ_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // Reference model state
    logic [15:0] m_q[$];
    bit          m_en = 1'b1;
    int          m_stats = 0;
    logic [15:0] m_done = 16'h0000;
    bit          m_done_pend = 1'b0;
    bit          m_bvalid = 1'b0;
    bit          m_aw_got = 1'b0;
    bit          m_w_got = 1'b0;
    logic [1:0]  m_aw_a = 2'd0;
    logic [31:0] m_w_d = 32'h0;
    bit          model_on = 1'b0;
    bit          host_done = 1'b0;

    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_mask_q[$];
    logic [15:0] exp_done_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_read(input logic [1:0] a, output logic [31:0] e, output logic [31:0] m);
        logic [15:0] st;
`ifdef PR_QUEUE_STATS_EN
        st = 16'(m_stats);
`else
        st = 16'h0000;
`endif
        e = 32'h0;
        m = 32'hFFFF_FFFF;
        case (a)
            2'd0: begin
                if (m_q.size() != 0) e = {1'b1, 15'h0, m_q[0]};
                else                 m = 32'h8000_0000;
            end
            2'd1:    e = {st, 6'h0, m_q.size() == 0, m_q.size() == DEPTH, 8'(m_q.size())};
            2'd2:    e = {16'h0, m_done};
            default: e = {31'h0, m_en};
        endcase
    endfunction

    // One model step: compare the registered outputs of the current cycle,
    // then predict what the coming clock edge will do.
    task automatic model_step();
        bit push, pop, flush, aw_hs, w_hs, commit;
        logic [1:0]  a;
        logic [31:0] d, e, m;
        check("req_ready", 32'(bus.req_ready), 32'(m_en && (m_q.size() < DEPTH)));
        check("pending", 32'(bus.pr_request_pending), 32'(m_q.size() != 0));
        check("done_valid", 32'(bus.done_valid), 32'(m_done_pend));
        check("bvalid", 32'(bus.s_axi_bvalid), 32'(m_bvalid));
        if (m_bvalid) check("aw_w_ready_in_resp", 32'({bus.s_axi_awready, bus.s_axi_wready}), 32'd0);
        m_done_pend = 1'b0;
        if (bus.s_axi_arvalid && bus.s_axi_arready) begin
            model_read(bus.s_axi_araddr, e, m);
            exp_rd_q.push_back(e);
            exp_mask_q.push_back(m);
        end
        push   = bus.req_valid && m_en && (m_q.size() < DEPTH);
        aw_hs  = bus.s_axi_awvalid && bus.s_axi_awready;
        w_hs   = bus.s_axi_wvalid && bus.s_axi_wready;
        commit = (m_aw_got || aw_hs) && (m_w_got || w_hs);
        a      = m_aw_got ? m_aw_a : bus.s_axi_awaddr;
        d      = m_w_got ? m_w_d : bus.s_axi_wdata;
        pop    = 1'b0;
        flush  = 1'b0;
        if (commit) begin
            case (a)
                2'd0: pop = (m_q.size() != 0);
                2'd2: begin
                    m_done      = d[15:0];
                    m_done_pend = 1'b1;
                    exp_done_q.push_back(d[15:0]);
                end
                2'd3: begin
                    m_en  = d[0];
                    flush = d[1];
                end
                default: ;
            endcase
            m_aw_got = 1'b0;
            m_w_got  = 1'b0;
        end else begin
            if (aw_hs) begin m_aw_got = 1'b1; m_aw_a = bus.s_axi_awaddr; end
            if (w_hs)  begin m_w_got = 1'b1;  m_w_d = bus.s_axi_wdata; end
        end
        if (m_bvalid && bus.s_axi_bready) m_bvalid = 1'b0;
        if (commit) m_bvalid = 1'b1;
        if (flush) begin
            m_q.delete();
            m_stats = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back(bus.req_data);
                if (m_stats < 65535) m_stats++;
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (model_on) model_step();
    end

    // Read data monitor
    initial forever begin
        @(negedge clk);
        if (model_on && bus.s_axi_rvalid && bus.s_axi_rready) begin
            if (exp_rd_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rdata_unexpected: got 0x%08h required no response", bus.s_axi_rdata);
            end else begin
                logic [31:0] e, m;
                e = exp_rd_q.pop_front();
                m = exp_mask_q.pop_front();
                check("rdata", bus.s_axi_rdata & m, e & m);
            end
        end
    end

    // Completion monitor
    initial forever begin
        @(negedge clk);
        if (model_on && bus.done_valid) begin
            if (exp_done_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL done_unexpected: got 0x%04h required no pulse", bus.done_id);
            end else begin
                logic [15:0] e;
                e = exp_done_q.pop_front();
                check("done_id", 32'(bus.done_id), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        bus.req_valid = 1'b1;
        bus.req_data  = d;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic axi_write(input logic [1:0] a, input logic [31:0] d,
                             input int aw_dly, input int w_dly, input int b_dly);
        int t;
        bit aw_done, w_done, aw_hs, w_hs, bv;
        bus.s_axi_awaddr = a;
        bus.s_axi_wdata  = d;
        aw_done = 1'b0;
        w_done  = 1'b0;
        t = 0;
        while (!(aw_done && w_done) && (t < 60)) begin
            bus.s_axi_awvalid = !aw_done && (t >= aw_dly);
            bus.s_axi_wvalid  = !w_done && (t >= w_dly);
            @(negedge clk);
            aw_hs = bus.s_axi_awvalid && bus.s_axi_awready;
            w_hs  = bus.s_axi_wvalid && bus.s_axi_wready;
            tick();
            if (aw_hs) aw_done = 1'b1;
            if (w_hs)  w_done = 1'b1;
            t++;
        end
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        check("aw_w_handshake", 32'(aw_done && w_done), 32'd1);
        if (!(aw_done && w_done)) return;
        t = 0;
        while (t < b_dly) begin
            tick();
            t++;
        end
        bus.s_axi_bready = 1'b1;
        bv = 1'b0;
        t  = 0;
        while (!bv && (t < 60)) begin
            @(negedge clk);
            bv = bus.s_axi_bvalid;
            tick();
            t++;
        end
        bus.s_axi_bready = 1'b0;
        check("b_handshake", 32'(bv), 32'd1);
    endtask

    task automatic axi_read(input logic [1:0] a, input int r_dly);
        int t;
        bit got;
        logic [31:0] first;
        bus.s_axi_araddr  = a;
        bus.s_axi_arvalid = 1'b1;
        got = 1'b0;
        t   = 0;
        while (!got && (t < 60)) begin
            @(negedge clk);
            got = bus.s_axi_arready;
            tick();
            t++;
        end
        bus.s_axi_arvalid = 1'b0;
        check("ar_handshake", 32'(got), 32'd1);
        if (!got) return;
        check("rvalid_next_cycle", 32'(bus.s_axi_rvalid), 32'd1);
        first = bus.s_axi_rdata;
        t = 0;
        while (t < r_dly) begin
            @(negedge clk);
            check("rvalid_hold", 32'(bus.s_axi_rvalid), 32'd1);
            check("rdata_hold", bus.s_axi_rdata, first);
            tick();
            t++;
        end
        bus.s_axi_rready = 1'b1;
        tick();
        bus.s_axi_rready = 1'b0;
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.req_valid     = 1'b0;
        bus.req_data      = 16'h0000;
        bus.s_axi_awaddr  = 2'd0;
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata   = 32'h0;
        bus.s_axi_wvalid  = 1'b0;
        bus.s_axi_bready  = 1'b0;
        bus.s_axi_araddr  = 2'd0;
        bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_pending", 32'(bus.pr_request_pending), 32'd0);
        check("rst_done", {15'h0, bus.done_valid, bus.done_id}, 32'd0);
        check("rst_axi_rdy_vld", 32'({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_bvalid,
                                      bus.s_axi_arready, bus.s_axi_rvalid}), 32'd0);
        check("rst_rdata", bus.s_axi_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        model_on = 1'b1;
        repeat (2) tick();

        // Reset status, single push and head peek
        axi_read(2'd1, 0);
        push(16'h00A5);
        axi_read(2'd0, 0);
        // Fill to full, pop, then simultaneous push and pop
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        push(16'h4444);
        axi_read(2'd1, 0);
        axi_write(2'd0, 32'h0, 0, 0, 0);
        fork
            push(16'h5555);
            axi_write(2'd0, 32'h0, 0, 0, 0);
        join
        axi_read(2'd1, 0);
        // DONE write with W leading AW and a stalled response
        axi_write(2'd2, 32'h0000_1234, 2, 0, 5);
        axi_read(2'd2, 3);
        // Flush with 2 queued, then disable
        axi_write(2'd0, 32'h0, 0, 0, 0);
        axi_read(2'd1, 0);
        axi_write(2'd3, 32'h3, 0, 0, 0);
        axi_read(2'd3, 0);
        axi_read(2'd1, 0);
        axi_write(2'd3, 32'h0, 1, 0, 0);
        push(16'h6666);
        axi_read(2'd1, 0);
        axi_write(2'd3, 32'h1, 0, 1, 1);
        // Three pushes then flush clears the statistics
        push(16'h7777);
        push(16'h8888);
        push(16'h9999);
        axi_read(2'd1, 0);
        axi_write(2'd3, 32'h3, 0, 0, 0);
        axi_read(2'd1, 0);

        // Randomized concurrent core and host traffic
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    int op;
                    op = $urandom_range(0, 6);
                    case (op)
                        0, 1: axi_read(2'($urandom_range(0, 3)), $urandom_range(0, 2));
                        2, 3: axi_write(2'd0, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
                        4: axi_write(2'd2, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
                        5: begin
                            int c;
                            c = $urandom_range(0, 5);
                            axi_write(2'd3, (c == 0) ? 32'h0 : ((c == 1) ? 32'h3 : 32'h1),
                                      $urandom_range(0, 2), $urandom_range(0, 2), 0);
                        end
                        default: axi_write(2'd1, $urandom, 0, 0, 0);
                    endcase
                    repeat ($urandom_range(0, 2)) tick();
                end
                axi_write(2'd3, 32'h1, 0, 0, 0);
                axi_read(2'd1, 0);
                host_done = 1'b1;
            end
            begin
                while (!host_done) begin
                    bus.req_valid = ($urandom_range(0, 2) != 0);
                    bus.req_data  = 16'($urandom);
                    tick();
                end
                bus.req_valid = 1'b0;
            end
        join

        repeat (5) tick();
        check("rd_scoreboard_drained", 32'(exp_rd_q.size()), 32'd0);
        check("done_scoreboard_drained", 32'(exp_done_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
